// File: rtl/arilla_bus_arbiter_pkg.sv
// Shared constants and types for the arilla bus arbiter and the peripheral interconnect.
package arilla_pkg;

  localparam int DefaultNumMasters = 3;
  localparam int MasterIdxWidth    = $clog2(DefaultNumMasters);
  localparam int ReadLatency       = 1;

  typedef logic [MasterIdxWidth-1:0] master_idx_t;

  typedef enum logic {
    LK_OPEN = 1'b0,
    LK_HELD = 1'b1
  } lock_state_t;

  function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
    return (idx + 32'd1 >= n) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/arilla_bus_arbiter_if.sv
// Shared arilla bus segment: one master side (the arbiter) and the slave segment.
interface arilla_bus_if #(
  parameter int AddressWidth = 30,
  parameter int DataWidth    = 32
);
  logic [AddressWidth-1:0] address;
  logic [DataWidth/8-1:0]  byte_enable;
  logic [DataWidth-1:0]    data_ctp;
  logic [DataWidth-1:0]    data_ptc;
  logic                    read;
  logic                    write;
  logic                    intercept;

  modport master (
    output address, byte_enable, data_ctp, read, write, intercept,
    input  data_ptc
  );

  modport slave (
    input  address, byte_enable, data_ctp, read, write, intercept,
    output data_ptc
  );
endinterface

// File: rtl/arilla_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first masked requester at or after the pointer, wrapping.
module arilla_rr_picker #(
  parameter  int N    = 3,
  localparam int IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    i_req,
  input  logic [IdxW-1:0] i_rr_ptr,
  input  logic [N-1:0]    i_mask,
  output logic [N-1:0]    o_grant,
  output logic [IdxW-1:0] o_winner,
  output logic            o_valid
);

  logic [N-1:0]    w_cand;
  logic [IdxW-1:0] w_idx;

  assign w_cand = i_req & i_mask;

  always_comb begin
    o_grant  = '0;
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int k = 0; k < N; k++) begin
      w_idx = IdxW'((int'(i_rr_ptr) + k) % N);
      if (!o_valid && w_cand[w_idx]) begin
        o_valid  = 1'b1;
        o_winner = w_idx;
      end
    end
    if (o_valid) o_grant[o_winner] = 1'b1;
  end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter with per-master lock sharing one arilla bus segment among NumMasters.
//   state   | meaning
//   LK_OPEN | round-robin among all requesters, pointer advances per beat
//   LK_HELD | only r_lock_owner may win, pointer frozen
module arilla_bus_arbiter
  import arilla_pkg::*;
#(
  parameter int NumMasters   = DefaultNumMasters,
  parameter int AddressWidth = 30,
  parameter int DataWidth    = 32
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NumMasters-1:0]                     m_read,
  input  logic [NumMasters-1:0]                     m_write,
  input  logic [NumMasters-1:0]                     m_lock,
  input  logic [NumMasters-1:0]                     m_intercept,
  input  logic [NumMasters-1:0][AddressWidth-1:0]   m_address,
  input  logic [NumMasters-1:0][DataWidth/8-1:0]    m_byte_enable,
  input  logic [NumMasters-1:0][DataWidth-1:0]      m_data_ctp,
  output logic [NumMasters-1:0]                     m_stall,
  output logic [NumMasters-1:0]                     m_rvalid,
  output logic [DataWidth-1:0]                      m_data_ptc,
  arilla_bus_if.master                              bus_interface
);

  localparam int IdxW = (NumMasters > 1) ? $clog2(NumMasters) : 1;

  lock_state_t r_lock_state, w_lock_state_nxt;
  logic [IdxW-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [IdxW-1:0] r_lock_owner, w_lock_owner_nxt;
  logic [IdxW-1:0] w_winner;
  logic [NumMasters-1:0] w_req, w_req_arb, w_mask, w_grant;
  logic w_granted;
  logic [ReadLatency-1:0] r_rsp_pending;
  logic [ReadLatency-1:0][IdxW-1:0] r_rsp_owner;

  assign w_req     = m_read | m_write;
  assign w_req_arb = rst_n ? w_req : '0;
  assign w_mask    = (r_lock_state == LK_HELD) ? (NumMasters'(1) << r_lock_owner) : '1;

  arilla_rr_picker #(.N(NumMasters)) u_picker (
    .i_req    (w_req_arb),
    .i_rr_ptr (r_rr_ptr),
    .i_mask   (w_mask),
    .o_grant  (w_grant),
    .o_winner (w_winner),
    .o_valid  (w_granted)
  );

  assign m_stall    = w_req & ~w_grant;
  assign m_data_ptc = bus_interface.data_ptc;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_state <= LK_OPEN;
      r_lock_owner <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_lock_state <= w_lock_state_nxt;
      r_lock_owner <= w_lock_owner_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
    end
  end

  always_comb begin
    w_lock_state_nxt = r_lock_state;
    w_lock_owner_nxt = r_lock_owner;
    w_rr_ptr_nxt     = r_rr_ptr;
    case (r_lock_state)
      LK_OPEN: begin
        if (w_granted) begin
          w_rr_ptr_nxt = IdxW'(wrap_inc(int'(w_winner), NumMasters));
          if (m_lock[w_winner]) begin
            w_lock_state_nxt = LK_HELD;
            w_lock_owner_nxt = w_winner;
          end
        end
      end
      // The owner always wins while held, so lock low covers both release cases.
      LK_HELD: if (!m_lock[r_lock_owner]) w_lock_state_nxt = LK_OPEN;
      default: w_lock_state_nxt = LK_OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rsp_pending <= '0;
      r_rsp_owner   <= '0;
    end else begin
      r_rsp_pending[0] <= w_granted & m_read[w_winner];
      r_rsp_owner[0]   <= w_winner;
      for (int s = 1; s < ReadLatency; s++) begin
        r_rsp_pending[s] <= r_rsp_pending[s-1];
        r_rsp_owner[s]   <= r_rsp_owner[s-1];
      end
    end
  end

  // Gated by rst_n so a response in flight when reset hits never surfaces.
  always_comb begin
    m_rvalid = '0;
    if (rst_n && r_rsp_pending[ReadLatency-1]) m_rvalid[r_rsp_owner[ReadLatency-1]] = 1'b1;
  end

  always_comb begin
    bus_interface.read        = 1'b0;
    bus_interface.write       = 1'b0;
    bus_interface.intercept   = 1'b0;
    bus_interface.address     = '0;
    bus_interface.byte_enable = '0;
    bus_interface.data_ctp    = '0;
    if (w_granted) begin
      bus_interface.read        = m_read[w_winner];
      bus_interface.write       = m_write[w_winner];
      bus_interface.intercept   = m_intercept[w_winner];
      bus_interface.address     = m_address[w_winner];
      bus_interface.byte_enable = m_byte_enable[w_winner];
      bus_interface.data_ctp    = m_data_ctp[w_winner];
    end
  end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Scoreboard bench for arilla_bus_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_arilla_bus_arbiter;
  import arilla_pkg::*;

  localparam int N  = 3;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int BW = DW / 8;

  logic clk = 1'b0;
  logic rst_n;
  logic preload;
  logic [N-1:0] m_read, m_write, m_lock, m_intercept, m_stall, m_rvalid;
  logic [N-1:0][AW-1:0] m_address;
  logic [N-1:0][BW-1:0] m_byte_enable;
  logic [N-1:0][DW-1:0] m_data_ctp;
  logic [DW-1:0] m_data_ptc;

  arilla_bus_if #(.AddressWidth(AW), .DataWidth(DW)) bus_if ();

  arilla_bus_arbiter #(.NumMasters(N), .AddressWidth(AW), .DataWidth(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .m_read        (m_read),
    .m_write       (m_write),
    .m_lock        (m_lock),
    .m_intercept   (m_intercept),
    .m_address     (m_address),
    .m_byte_enable (m_byte_enable),
    .m_data_ctp    (m_data_ctp),
    .m_stall       (m_stall),
    .m_rvalid      (m_rvalid),
    .m_data_ptc    (m_data_ptc),
    .bus_interface (bus_if)
  );

  always #5 clk = ~clk;

  // Slave RAM with registered read, 256 words, preloaded with address*2
  logic [DW-1:0] ram [256];
  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 256; a++) ram[a] <= DW'(a * 2);
    end else begin
      if (bus_if.read) bus_if.data_ptc <= ram[bus_if.address[7:0]];
      if (bus_if.write)
        for (int b = 0; b < BW; b++)
          if (bus_if.byte_enable[b]) ram[bus_if.address[7:0]][8*b +: 8] <= bus_if.data_ctp[8*b +: 8];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req_v);
    checks++;
    if (act !== req_v) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req_v, cyc);
    end
  endtask

  // Reference model state
  typedef struct {
    int            owner;
    logic [DW-1:0] data;
    int            cyc;
  } rsp_t;
  rsp_t exp_q[$];
  logic [DW-1:0] mdl_mem [256];
  int mp = 0;
  bit mlocked = 0;
  int mowner = 0;
  int wait_b [N];

  logic [N-1:0] snap_stall, snap_rvalid, snap_req;
  logic [DW-1:0] snap_data;

  function automatic int dut_winner();
    for (int i = 0; i < N; i++) if (snap_req[i] && !snap_stall[i]) return i;
    return -1;
  endfunction

  // One clock cycle: inputs are already applied; checks at negedge, returns at next posedge+1
  task automatic step();
    int w;
    int idx;
    logic [N-1:0] req, acc, exp_stall;
    logic exp_rd, exp_wr, exp_ic;
    logic [AW-1:0] exp_a;
    logic [BW-1:0] exp_be;
    logic [DW-1:0] exp_d;
    req = m_read | m_write;
    assert (!(|(m_read & m_write))) else $error("FAIL rw_exclusive stimulus drove read and write together");
    if (!rst_n) begin
      exp_q.delete();
      for (int i = 0; i < N; i++) wait_b[i] = 0;
    end
    w = -1;
    if (rst_n)
      for (int k = 0; k < N; k++) begin
        idx = (mp + k) % N;
        if (w < 0 && req[idx] && (!mlocked || idx == mowner)) w = idx;
      end
    @(negedge clk);
    snap_stall  = m_stall;
    snap_rvalid = m_rvalid;
    snap_data   = m_data_ptc;
    snap_req    = req;
    exp_stall = req;
    exp_rd = 1'b0; exp_wr = 1'b0; exp_ic = 1'b0; exp_a = '0; exp_be = '0; exp_d = '0;
    if (w >= 0) begin
      exp_stall[w] = 1'b0;
      exp_rd = m_read[w]; exp_wr = m_write[w]; exp_ic = m_intercept[w];
      exp_a = m_address[w]; exp_be = m_byte_enable[w]; exp_d = m_data_ctp[w];
    end
    chk("stall", 64'(m_stall), 64'(exp_stall));
    chk("bus_read", 64'(bus_if.read), 64'(exp_rd));
    chk("bus_write", 64'(bus_if.write), 64'(exp_wr));
    chk("bus_intercept", 64'(bus_if.intercept), 64'(exp_ic));
    chk("bus_address", 64'(bus_if.address), 64'(exp_a));
    chk("bus_byte_enable", 64'(bus_if.byte_enable), 64'(exp_be));
    chk("bus_data_ctp", 64'(bus_if.data_ctp), 64'(exp_d));
    acc = req & ~m_stall;
    chk("one_grant", 64'($countones(acc) <= 1), 64'(1));
    // Fairness measured on DUT acceptances; lock periods are exempt
    if (mlocked || (w >= 0 && m_lock[w]) || !rst_n) begin
      for (int i = 0; i < N; i++) wait_b[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (req[i] && m_stall[i] && acc != '0) begin
          wait_b[i]++;
          chk("fair_wait", 64'(wait_b[i] <= N - 1), 64'(1));
        end else if (!req[i] || !m_stall[i]) begin
          wait_b[i] = 0;
        end
      end
    end
    if (w >= 0) begin
      if (m_read[w]) exp_q.push_back('{owner: w, data: mdl_mem[m_address[w][7:0]], cyc: cyc});
      if (m_write[w])
        for (int b = 0; b < BW; b++)
          if (m_byte_enable[w][b]) mdl_mem[m_address[w][7:0]][8*b +: 8] = m_data_ctp[w][8*b +: 8];
      if (!mlocked) begin
        mp = (w + 1) % N;
        if (m_lock[w]) begin
          mlocked = 1;
          mowner  = w;
        end
      end else if (!m_lock[w]) begin
        mlocked = 0;
      end
    end else if (mlocked && !m_lock[mowner]) begin
      mlocked = 0;
    end
    if (!rst_n) begin
      mp = 0; mlocked = 0; mowner = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m_read = '0; m_write = '0; m_lock = '0; m_intercept = '0;
    m_address = '0; m_byte_enable = '0; m_data_ctp = '0;
  endtask

  task automatic set_m(input int i, input bit rd, input bit wr, input bit lk,
                       input logic [AW-1:0] a, input logic [BW-1:0] be, input logic [DW-1:0] d);
    m_read[i] = rd; m_write[i] = wr; m_lock[i] = lk; m_intercept[i] = 1'b0;
    m_address[i] = a; m_byte_enable[i] = be; m_data_ctp[i] = d;
  endtask

  task automatic do_reset();
    idle_all();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Response monitor: anything older than this cycle at the queue head must be presented now
  initial begin : monitor
    rsp_t e;
    logic [N-1:0] ev;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        ev = '0;
        ev[e.owner] = 1'b1;
        chk("rvalid_route", 64'(m_rvalid), 64'(ev));
        if (m_rvalid != '0) chk("rdata", 64'(m_data_ptc), 64'(e.data));
      end else if (m_rvalid != '0) begin
        chk("rvalid_spurious", 64'(m_rvalid), 64'(0));
      end
    end
  end

  int t1_win [4] = '{0, 1, 2, 0};
  logic [DW-1:0] t1_data [3] = '{32'h20, 32'h40, 32'h60};
  int r;

  initial begin : driver
    for (int a = 0; a < 256; a++) mdl_mem[a] = DW'(a * 2);
    for (int i = 0; i < N; i++) wait_b[i] = 0;
    idle_all();
    preload = 1'b1;
    rst_n = 1'b0;
    set_m(0, 1, 0, 0, 'h10, 4'hF, '0);
    set_m(1, 1, 0, 0, 'h20, 4'hF, '0);
    set_m(2, 1, 0, 0, 'h30, 4'hF, '0);
    @(posedge clk);
    #1;
    preload = 1'b0;

    // Reset state with all three requesting
    step();
    chk("reset_stall", 64'(snap_stall), 64'(3'b111));
    chk("reset_rvalid", 64'(snap_rvalid), 64'(0));

    // Continuous reads from three masters
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t1_grant_order", 64'(dut_winner()), 64'(t1_win[k]));
      if (k > 0) begin
        chk("t1_rvalid", 64'(snap_rvalid), 64'(1 << t1_win[k-1]));
        chk("t1_rdata", 64'(snap_data), 64'(t1_data[k-1]));
      end
    end

    // Single master: partial write then read back
    do_reset();
    set_m(2, 0, 1, 0, 'h40, 4'b0011, 32'hDEADBEEF);
    step();
    chk("t2_write_nostall", 64'(snap_stall), 64'(0));
    set_m(2, 1, 0, 0, 'h40, 4'hF, '0);
    step();
    chk("t2_read_nostall", 64'(snap_stall), 64'(0));
    idle_all();
    step();
    chk("t2_rvalid", 64'(snap_rvalid), 64'(3'b100));
    chk("t2_rdata", 64'(snap_data), 64'(32'h0000BEEF));

    // Lock sequence by master 1 against continuous master 0
    do_reset();
    set_m(0, 1, 0, 0, 'h10, 4'hF, '0);
    step();
    for (int k = 0; k < 4; k++) begin
      if (k < 3) set_m(1, 0, 1, 1, AW'(32'h50 + k), 4'hF, 32'h1000 + k);
      else       set_m(1, 1, 0, 0, 'h50, 4'hF, '0);
      step();
      chk("t3_m0_stall", 64'(snap_stall[0]), 64'(1));
      chk("t3_m1_grant", 64'(snap_stall[1]), 64'(0));
    end
    set_m(1, 0, 0, 0, '0, '0, '0);
    step();
    chk("t3_m0_after_lock", 64'(snap_stall[0]), 64'(0));
    idle_all();
    step();

    // Read from master 0 followed by write from master 1
    do_reset();
    set_m(0, 1, 0, 0, 'h20, 4'hF, '0);
    step();
    idle_all();
    set_m(1, 0, 1, 0, 'h21, 4'hF, 32'h12345678);
    step();
    chk("t4_rvalid", 64'(snap_rvalid), 64'(3'b001));
    chk("t4_rdata", 64'(snap_data), 64'(32'h40));
    idle_all();
    step();
    chk("t4_no_rvalid", 64'(snap_rvalid), 64'(0));

    // Reset right after an accepted read
    do_reset();
    set_m(1, 1, 0, 0, 'h10, 4'hF, '0);
    step();
    rst_n = 1'b0;
    set_m(0, 1, 0, 0, 'h11, 4'hF, '0);
    set_m(2, 1, 0, 0, 'h12, 4'hF, '0);
    step();
    chk("t5_rvalid_dropped", 64'(snap_rvalid), 64'(0));
    rst_n = 1'b1;
    step();
    chk("t5_first_grant", 64'(snap_stall), 64'(3'b110));
    idle_all();
    step();
    step();
    step();

    // Randomized traffic with occasional resets
    do_reset();
    for (int c = 0; c < 10000; c++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < N; i++) begin
        if (!snap_stall[i]) begin
          r = $urandom_range(0, 99);
          m_read[i]        = (r < 35);
          m_write[i]       = (r >= 35 && r < 60);
          m_lock[i]        = ($urandom_range(0, 99) < 10);
          m_intercept[i]   = 1'($urandom_range(0, 1));
          m_address[i]     = AW'($urandom_range(0, 255));
          m_byte_enable[i] = BW'($urandom_range(0, 15));
          m_data_ctp[i]    = $urandom;
        end
      end
      step();
    end
    rst_n = 1'b1;
    idle_all();
    step();
    step();
    step();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
